hash_addr_generator: RTL and testbench
======================================

// Module: hash_addr_generator
// PURPOSE
//   Upstream stage of the K-hot address Decoder. Accepts one key word per valid/ready
//   transaction and runs an LFSR hash to generate K bucket addresses, one per cycle.
//   Presents them packed on generated_addr, held until the downstream stage accepts them.
//   Chunk i occupies generated_addr[BIT*(i+1)-1 : BIT*i], matching the Decoder's input layout.
// PARAMETERS
//   SIZE      8                Number of buckets; every emitted address is < SIZE.
//   K         4                Addresses per key; must satisfy 1 <= K <= SIZE.
//   BIT       $clog2(SIZE)     Width of one address chunk.
//   DATA_W    8                Key width; also the LFSR width.
//   TAPS      8'hB8            Galois LFSR feedback mask, width DATA_W.
//   SEED      8'hA5            XOR seed applied to the key; must be nonzero.
//   MAX_RETRY 15               Duplicate-retry cap; used only with DISTINCT_ADDR_EN.
// PORTS
//   clk             in   1          Rising-edge clock.
//   rst_n           in   1          Asynchronous, active-low reset.
//   in_valid        in   1          A key is offered.
//   in_ready        out  1          Block can accept a key.
//   in_data         in   DATA_W     Key.
//   out_valid       out  1          generated_addr holds a complete set.
//   out_ready       in   1          Consumer accepts the set.
//   generated_addr  out  K*BIT      Packed addresses.
//   busy            out  1          High in the GEN state.
// BEHAVIOUR
//   - States:
//     - IDLE: in_ready=1, out_valid=0.
//     - GEN: generation in progress.
//     - DONE: out_valid=1, in_ready=0.
//   - Reset (async assert, synchronous to clk on release):
//     - state=IDLE, lfsr=0, cnt=0, generated_addr=0, out_valid=0, busy=0, retry=0.
//   - IDLE, on in_valid&&in_ready:
//     - lfsr <= in_data^SEED; if that value is 0, lfsr <= SEED (prevents LFSR lock-up).
//     - cnt <= 0; state -> GEN.
//   - GEN, every cycle:
//     - nxt = (lfsr>>1) ^ (lfsr[0] ? TAPS : 0); lfsr <= nxt.
//     - a = nxt[BIT-1:0]; if a >= SIZE then a = a-SIZE. A single subtraction is sufficient.
//     - Chunk cnt <= a; cnt <= cnt+1.
//     - When cnt==K-1 the write completes the set and state -> DONE.
//   - Latency: the acceptance edge is followed by K GEN edges. out_valid rises after the
//     K-th GEN edge, i.e. K+1 cycles after acceptance.
//   - DONE:
//     - generated_addr and out_valid are held stable until out_ready=1.
//     - On out_valid&&out_ready: state -> IDLE. in_ready rises the following cycle.
//     - A key is never accepted in the same cycle as an output handshake.
//   - Chunks not yet written in the current GEN pass keep their previous values.
//     Consumers must use generated_addr only while out_valid=1.
//   - in_data is sampled only at acceptance; later changes have no effect.
//   - rst_n low mid-GEN or mid-DONE: immediate return to the reset values; any partial
//     set is discarded.
//   - Duplicate chunks are legal output; the Decoder ORs them together.
// CONFIGURATION
//   DISTINCT_ADDR_EN defined:
//     - In GEN, if a equals any already-written chunk 0..cnt-1, the LFSR still steps, but
//       the chunk is not written and cnt holds.
//     - The retry counter increments on each rejected attempt. At MAX_RETRY the duplicate
//       is accepted and written.
//     - The retry counter clears on every chunk write.
//     - Latency becomes K+1+retries cycles.
//   DISTINCT_ADDR_EN undefined:
//     - No compare logic and no retry counter; latency is fixed at K+1 cycles.
// TESTING (defaults: SIZE=8, K=4, DATA_W=8, TAPS=B8, SEED=A5)
//   1. Reset: assert rst_n=0 mid-run.
//      -> out_valid=0, in_ready=0 during reset; generated_addr=0.
//      -> in_ready=1 on the first cycle after release.
//   2. Basic set, macro undefined: in_data=8'h00 (lfsr=A5).
//      -> LFSR steps EA,75,82,41 give chunks 2,5,2,1.
//      -> generated_addr=12'h2AA; out_valid asserted 5 cycles after acceptance.
//   3. Zero-seed guard: in_data=8'hA5 (A5^SEED=0).
//      -> LFSR loads A5; result identical to test 2 (12'h2AA).
//   4. Backpressure: hold out_ready=0 for 10 cycles in DONE.
//      -> generated_addr stable, in_valid ignored, in_ready=0.
//      -> out_ready=1: IDLE next cycle, then accept the next key.
//   5. DISTINCT_ADDR_EN, in_data=8'h00: duplicate 2 rejected at step 3.
//      -> chunks 2,5,1,0; generated_addr=12'h06A.
//      -> out_valid asserted 6 cycles after acceptance.
//   6. Reset mid-GEN: deassert rst_n after 2 GEN cycles.
//      -> state IDLE, outputs zero; a fresh key yields a correct full set.

Source files
------------

// File: rtl/hash_addr_generator.sv
// ---------------------------------------------------------------------------
// hash_addr_generator
//
// Upstream stage of the K-hot address decoder. One key is accepted per
// valid/ready handshake. The key seeds a Galois LFSR. The LFSR then steps once
// per cycle, and each step yields one bucket address below SIZE. When K
// addresses have been collected, they are presented packed on generated_addr.
// They are held there until the downstream stage accepts them.
//
// Chunk i occupies generated_addr[BIT*(i+1)-1 : BIT*i].
//
// Optional feature (compile-time macro DISTINCT_ADDR_EN):
//   When this macro is defined, a candidate address that equals a chunk
//   already written in the current set is rejected. The LFSR still steps, and
//   the slot is retried on the next cycle. After MAX_RETRY consecutive
//   rejections, the duplicate is accepted so that the set always completes.
//   When the macro is undefined, duplicates are written as-is and the latency
//   is fixed at K+1 cycles.
//
// Ports:
//   clk             in   1        rising-edge clock
//   rst_n           in   1        asynchronous active-low reset
//   in_valid        in   1        a key is offered
//   in_ready        out  1        block can accept a key (IDLE only)
//   in_data         in   DATA_W   key, sampled only at acceptance
//   out_valid       out  1        generated_addr holds a complete set
//   out_ready       in   1        consumer accepts the set
//   generated_addr  out  K*BIT    packed bucket addresses
//   busy            out  1        high while addresses are being generated
// ---------------------------------------------------------------------------
module hash_addr_generator #(
  parameter int                SIZE      = 8,
  parameter int                K         = 4,
  parameter int                BIT       = $clog2(SIZE),
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] TAPS      = 8'hB8,
  parameter logic [DATA_W-1:0] SEED      = 8'hA5,
  parameter int                MAX_RETRY = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [K*BIT-1:0]   generated_addr,
  output logic               busy
);

  // The chunk counter must be at least one bit wide, even when K == 1.
  localparam int              CNT_W    = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(K - 1);
  // SIZE may equal 2**BIT, so the fold comparison uses one extra bit.
  localparam logic [BIT:0]    SIZE_EXT = (BIT + 1)'(SIZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  logic [DATA_W-1:0]  lfsr_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [K*BIT-1:0]   generated_addr_r;
  logic               out_valid_r;
  logic               in_ready_r;
  logic               busy_r;

  logic [DATA_W-1:0]  nxt_s;
  logic [DATA_W-1:0]  load_s;
  logic [BIT-1:0]     addr_s;
  logic               write_en_s;
  logic [K*BIT-1:0]   gen_next_s;

  // Galois LFSR step: shift right, and fold in the taps when bit 0 leaves.
  always_comb begin
    if (lfsr_r[0]) begin
      nxt_s = (lfsr_r >> 1) ^ TAPS;
    end else begin
      nxt_s = lfsr_r >> 1;
    end
  end

  // Fold the low LFSR bits into [0, SIZE). One subtraction is enough because
  // the raw value is below 2**BIT, which is at most 2*SIZE.
  always_comb begin
    if ({1'b0, nxt_s[BIT-1:0]} >= SIZE_EXT) begin
      addr_s = BIT'({1'b0, nxt_s[BIT-1:0]} - SIZE_EXT);
    end else begin
      addr_s = nxt_s[BIT-1:0];
    end
  end

  // Seed the LFSR from the key. An all-zero state would lock the LFSR, so it
  // is replaced by SEED.
  always_comb begin
    if ((in_data ^ SEED) == {DATA_W{1'b0}}) begin
      load_s = SEED;
    end else begin
      load_s = in_data ^ SEED;
    end
  end

`ifdef DISTINCT_ADDR_EN
  localparam int               RETRY_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RETRY_W-1:0] RETRY_CAP = RETRY_W'(MAX_RETRY);

  logic [RETRY_W-1:0] retry_r;
  logic               dup_s;

  // Compare the candidate against every chunk already written in this pass.
  always_comb begin
    dup_s = 1'b0;
    for (int i = 0; i < K; i++) begin
      dup_s = dup_s | ((CNT_W'(i) < cnt_r) &&
                       (generated_addr_r[i*BIT +: BIT] == addr_s));
    end
  end

  // Reject a duplicate unless the retry budget is exhausted.
  always_comb begin
    if (dup_s && (retry_r < RETRY_CAP)) begin
      write_en_s = 1'b0;
    end else begin
      write_en_s = 1'b1;
    end
  end

  // Retry counter: counts consecutive rejections for the current slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_r <= {RETRY_W{1'b0}};
    end else if (state_r != ST_GEN) begin
      retry_r <= {RETRY_W{1'b0}};
    end else if (write_en_s) begin
      retry_r <= {RETRY_W{1'b0}};
    end else begin
      retry_r <= retry_r + RETRY_W'(1);
    end
  end
`else
  // Without the distinct-address feature, every GEN cycle writes a chunk.
  assign write_en_s = 1'b1;
`endif

  // Next packed vector: only the slot selected by cnt_r takes the new
  // address. Slots not yet written keep their previous contents.
  always_comb begin
    gen_next_s = generated_addr_r;
    for (int i = 0; i < K; i++) begin
      if (write_en_s && (cnt_r == CNT_W'(i))) begin
        gen_next_s[i*BIT +: BIT] = addr_s;
      end else begin
        gen_next_s[i*BIT +: BIT] = generated_addr_r[i*BIT +: BIT];
      end
    end
  end

  // Control FSM with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r          <= ST_IDLE;
      lfsr_r           <= {DATA_W{1'b0}};
      cnt_r            <= {CNT_W{1'b0}};
      generated_addr_r <= {(K*BIT){1'b0}};
      out_valid_r      <= 1'b0;
      in_ready_r       <= 1'b0;
      busy_r           <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready_r) begin
            lfsr_r     <= load_s;
            cnt_r      <= {CNT_W{1'b0}};
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= ST_GEN;
          end else begin
            in_ready_r <= 1'b1;
          end
        end
        ST_GEN: begin
          lfsr_r           <= nxt_s;
          generated_addr_r <= gen_next_s;
          if (write_en_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (cnt_r == LAST_CNT) begin
              out_valid_r <= 1'b1;
              busy_r      <= 1'b0;
              state_r     <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          // in_ready stays low here, so a key can never be accepted in the
          // same cycle as the output handshake.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r          <= ST_IDLE;
          lfsr_r           <= {DATA_W{1'b0}};
          cnt_r            <= {CNT_W{1'b0}};
          generated_addr_r <= {(K*BIT){1'b0}};
          out_valid_r      <= 1'b0;
          in_ready_r       <= 1'b0;
          busy_r           <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready       = in_ready_r;
  assign out_valid      = out_valid_r;
  assign generated_addr = generated_addr_r;
  assign busy           = busy_r;

endmodule

// File: tb/tb_hash_addr_generator.sv
// ---------------------------------------------------------------------------
// tb_hash_addr_generator
//
// Scoreboard bench for hash_addr_generator (SIZE=8, K=4, DATA_W=8, TAPS=B8,
// SEED=A5). Expected sets and latencies are pushed when a key is driven and
// popped when the DUT presents out_valid. Known reference vectors use literal
// sets; other keys use a small behavioural hash model.
// ---------------------------------------------------------------------------
module tb_hash_addr_generator;

  localparam int K   = 4;
  localparam int BIT = 3;

`ifdef DISTINCT_ADDR_EN
  localparam logic [11:0] KNOWN_SET = 12'h06A;
  localparam int          KNOWN_LAT = 6;
`else
  localparam logic [11:0] KNOWN_SET = 12'h2AA;
  localparam int          KNOWN_LAT = 5;
`endif

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] generated_addr;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [11:0] exp_q[$];
  int          lat_q[$];

  hash_addr_generator dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_data        (in_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .generated_addr (generated_addr),
    .busy           (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Behavioural hash: returns the packed set and the expected latency.
  function automatic logic [11:0] model_set(input logic [7:0] key, output int lat);
    logic [7:0] l;
    logic [2:0] ch [4];
    logic [2:0] a;
    logic [11:0] packed_set;
    int n;
    int retries;
    l = key ^ 8'hA5;
    if (l == 8'h00) l = 8'hA5;
    for (int j = 0; j < 4; j++) ch[j] = 3'd0;
    n = 0;
    retries = 0;
    lat = 1;
    while (n < 4) begin
      l = l[0] ? ((l >> 1) ^ 8'hB8) : (l >> 1);
      a = l[2:0];
      lat++;
`ifdef DISTINCT_ADDR_EN
      begin
        bit dup;
        dup = 1'b0;
        for (int j = 0; j < n; j++) if (ch[j] == a) dup = 1'b1;
        if (dup && retries < 15) begin
          retries++;
          continue;
        end
      end
`endif
      ch[n] = a;
      n++;
      retries = 0;
    end
    packed_set = {ch[3], ch[2], ch[1], ch[0]};
    return packed_set;
  endfunction

  // Wait for in_ready (bounded), then offer a key for one cycle. The task
  // returns at the negedge after the acceptance edge.
  task automatic start_key(input logic [7:0] key);
    int cyc;
    cyc = 0;
    while (!in_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check_val("in_ready_before_key", {31'd0, in_ready}, 32'd1);
    in_data  = key;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
  endtask

  // Full transaction: push the expectation, run the key, wait for out_valid,
  // apply backpressure for hold cycles, then compare and handshake.
  task automatic run_key(input logic [7:0] key, input int hold,
                         input bit use_known);
    int cyc;
    int lat;
    logic [11:0] exp_set;
    logic [11:0] m;
    m = model_set(key, lat);
    if (use_known) begin
      exp_q.push_back(KNOWN_SET);
      lat_q.push_back(KNOWN_LAT);
    end else begin
      exp_q.push_back(m);
      lat_q.push_back(lat);
    end
    start_key(key);
    check_val("busy_in_gen", {31'd0, busy}, 32'd1);
    check_val("in_ready_in_gen", {31'd0, in_ready}, 32'd0);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_val("latency", cyc, lat_q.pop_front());
    exp_set = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      check_val("bp_addr_stable", {20'd0, generated_addr}, {20'd0, exp_set});
      check_val("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check_val("bp_in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_val("addr_set", {20'd0, generated_addr}, {20'd0, exp_set});
    check_val("busy_in_done", {31'd0, busy}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val("out_valid_after_hs", {31'd0, out_valid}, 32'd0);
    check_val("in_ready_after_hs", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check_val({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check_val({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_addr"}, {20'd0, generated_addr}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cyc;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    @(negedge clk);
    check_val("in_ready_after_por", {31'd0, in_ready}, 32'd1);

    // Reference key 00 and the zero-seed guard key A5 give the same set.
    run_key(8'h00, 0, 1'b1);
    run_key(8'hA5, 0, 1'b1);

    // Backpressure for 10 cycles, then accept the next key straight away.
    run_key(8'h3C, 10, 1'b0);
    run_key(8'hC3, 0, 1'b0);

    // Reset while DONE: the finished set is discarded.
    start_key(8'h11);
    cyc = 1;
    while (!out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_val("reach_done", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_done");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("in_ready_after_rst_done", {31'd0, in_ready}, 32'd1);

    // Reset after two GEN cycles: the partial set is discarded.
    start_key(8'h5A);
    @(negedge clk);
    @(negedge clk);
    check_val("busy_before_rst", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_gen");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_val("in_ready_after_rst_gen", {31'd0, in_ready}, 32'd1);
    run_key(8'h00, 2, 1'b1);

    // A few random keys against the model.
    for (int i = 0; i < 6; i++) begin
      run_key(8'($urandom), i % 3, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
